cache_fill_arbiter: RTL and testbench

Sequential arbiter and sequencer that shares the single pipelined main-memory port between the instruction-cache and data-cache miss handlers. It grants one requester at a time and streams a full block fill of 8 sequential word reads, steering returned words to the granted cache. It also performs single-word write-through stores from the data cache. It sits between `ICACHE`/`DCACHE` and the 4-cycle main memory in the `cpu` top level.

---
 rtl/cache_fill_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
// ---------------------------------------------------------------------------
// cache_fill_arbiter
//
// Shares the single pipelined main-memory port between the I-cache and
// D-cache miss handlers. One requester is granted at a time. A fill streams
// WORDS back-to-back word reads of the missing block and steers the returned
// words (counted by mem_rvalid, so any memory latency works) into the granted
// cache. A D-cache write-through store is a single one-cycle write.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : an I/D fill tie in IDLE goes to the side not most recently
//               granted a fill (D wins the first tie after reset).
//   undefined : fixed priority d_wr > d_miss > i_miss.
//   d_wr is always the highest priority.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_miss / i_miss_addr     I-cache fill request and miss byte address
//   d_miss / d_miss_addr     D-cache fill request and miss byte address
//   d_wr / d_wr_addr / d_wr_data  D-cache write-through store request
//   mem_en/mem_wr/mem_addr/mem_wdata  memory request (combinational)
//   mem_rdata / mem_rvalid   memory read return (in issue order)
//   fill_data / fill_word    returned word and its index within the block
//   i_fill_we / d_fill_we    write strobe into the granted cache data array
//   i_fill_done/d_fill_done  one-cycle pulse with the last fill word
//   wr_done                  one-cycle pulse while the store is issued
//   busy                     arbiter not idle
// ---------------------------------------------------------------------------
module cache_fill_arbiter #(
  parameter int WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_miss,
  input  logic [15:0]              i_miss_addr,
  input  logic                     d_miss,
  input  logic [15:0]              d_miss_addr,
  input  logic                     d_wr,
  input  logic [15:0]              d_wr_addr,
  input  logic [15:0]              d_wr_data,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [15:0]              mem_addr,
  output logic [15:0]              mem_wdata,
  input  logic [15:0]              mem_rdata,
  input  logic                     mem_rvalid,
  output logic [15:0]              fill_data,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic                     i_fill_we,
  output logic                     d_fill_we,
  output logic                     i_fill_done,
  output logic                     d_fill_done,
  output logic                     wr_done,
  output logic                     busy
);

  localparam int AW = $clog2(WORDS);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_I_FILL  = 2'd1;
  localparam logic [1:0] ST_D_FILL  = 2'd2;
  localparam logic [1:0] ST_D_WRITE = 2'd3;

  localparam logic [CW-1:0] CNT_WORDS = CW'(WORDS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(WORDS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  // Clears the byte-within-block bits (block = 2*WORDS bytes).
  localparam logic [15:0]   BLK_MASK  = ~16'(2 * WORDS - 1);

  logic [1:0]    state_q, state_d;
  logic [15:0]   base_q, base_d;
  logic [CW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] ret_cnt_q, ret_cnt_d;
  logic          grant_i_s, grant_d_s;
  logic          fill_st_s, last_ret_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic          last_i_q, last_i_d;   // 1: I side was the last fill granted
`endif

  assign fill_st_s  = (state_q == ST_I_FILL) || (state_q == ST_D_FILL);
  assign last_ret_s = fill_st_s && mem_rvalid && (ret_cnt_q == CNT_LAST);

  // Fill arbitration between the two miss handlers (stores handled separately)
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (d_miss && i_miss) begin
      grant_d_s = last_i_q;
      grant_i_s = ~last_i_q;
    end else if (d_miss) begin
      grant_d_s = 1'b1;
    end else if (i_miss) begin
      grant_i_s = 1'b1;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
`else
    if (d_miss) begin
      grant_d_s = 1'b1;
    end else if (i_miss) begin
      grant_i_s = 1'b1;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
`endif
  end

  // Next-state, block base latch and issue/return counters
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    case (state_q)
      ST_IDLE: begin
        issue_cnt_d = CNT_ZERO;
        ret_cnt_d   = CNT_ZERO;
        if (d_wr) begin
          state_d = ST_D_WRITE;
        end else if (grant_d_s) begin
          state_d = ST_D_FILL;
          base_d  = d_miss_addr & BLK_MASK;
        end else if (grant_i_s) begin
          state_d = ST_I_FILL;
          base_d  = i_miss_addr & BLK_MASK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_I_FILL, ST_D_FILL: begin
        // Issue counter saturates at WORDS; reads stop once all are issued.
        if (issue_cnt_q < CNT_WORDS) begin
          issue_cnt_d = issue_cnt_q + CNT_ONE;
        end else begin
          issue_cnt_d = issue_cnt_q;
        end
        if (last_ret_s) begin
          state_d     = ST_IDLE;
          issue_cnt_d = CNT_ZERO;
          ret_cnt_d   = CNT_ZERO;
        end else if (mem_rvalid) begin
          ret_cnt_d = ret_cnt_q + CNT_ONE;
        end else begin
          ret_cnt_d = ret_cnt_q;
        end
      end
      ST_D_WRITE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        issue_cnt_d = CNT_ZERO;
        ret_cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, base and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= 16'h0000;
      issue_cnt_q <= CNT_ZERO;
      ret_cnt_q   <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember which side received the last fill grant (stores do not count)
  always_comb begin
    last_i_d = last_i_q;
    if ((state_q == ST_IDLE) && !d_wr && grant_d_s) begin
      last_i_d = 1'b0;
    end else if ((state_q == ST_IDLE) && !d_wr && grant_i_s) begin
      last_i_d = 1'b1;
    end else begin
      last_i_d = last_i_q;
    end
  end

  // Last-served register; resets to I so D wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_i_q <= 1'b1;
    end else begin
      last_i_q <= last_i_d;
    end
  end
`endif

  // Memory port and fill steering, decoded from state and counters
  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = 16'h0000;
    mem_wdata   = 16'h0000;
    fill_data   = 16'h0000;
    fill_word   = {AW{1'b0}};
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    wr_done     = 1'b0;
    case (state_q)
      ST_D_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        wr_done   = 1'b1;
      end
      ST_I_FILL, ST_D_FILL: begin
        if (issue_cnt_q < CNT_WORDS) begin
          mem_en   = 1'b1;
          mem_addr = base_q | {{(15 - AW){1'b0}}, issue_cnt_q[AW-1:0], 1'b0};
        end else begin
          mem_en = 1'b0;
        end
        if (mem_rvalid) begin
          fill_data   = mem_rdata;
          fill_word   = ret_cnt_q[AW-1:0];
          i_fill_we   = (state_q == ST_I_FILL);
          d_fill_we   = (state_q == ST_D_FILL);
          i_fill_done = last_ret_s && (state_q == ST_I_FILL);
          d_fill_done = last_ret_s && (state_q == ST_D_FILL);
        end else begin
          fill_data = 16'h0000;
        end
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
module tb_cache_fill_arbiter;

  localparam int WORDS = 8;
  localparam int AW    = $clog2(WORDS);
  localparam int LAT   = 4;
  localparam logic [15:0] BLK_MASK = ~16'(2 * WORDS - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_miss = 1'b0, d_miss = 1'b0, d_wr = 1'b0;
  logic [15:0] i_miss_addr = 16'h0000, d_miss_addr = 16'h0000;
  logic [15:0] d_wr_addr = 16'h0000, d_wr_data = 16'h0000;
  logic mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic [15:0] mem_rdata = 16'h0000;
  logic mem_rvalid = 1'b0;
  logic [AW-1:0] fill_word;
  logic i_fill_we, d_fill_we, i_fill_done, d_fill_done, wr_done, busy;

  cache_fill_arbiter #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .wr_done(wr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic wr; logic [15:0] addr; logic [15:0] wdata; } iss_t;
  typedef struct { int cyc; logic d; int word; logic [15:0] data; logic done; } fil_t;

  iss_t iss_q[$], exp_iss[$];
  fil_t fil_q[$], exp_fil[$];
  int   idone_q[$], ddone_q[$], wrdone_q[$], dn_order[$];
  bit   saw_idone = 1'b0, saw_ddone = 1'b0, saw_wrdone = 1'b0;
  bit   hold_i = 1'b0, hold_d = 1'b0;
  int   total = 0, bad = 0, cyc = 0;

  // ---------------- memory environment: fixed LAT-cycle pipelined reads ----
  logic [15:0] memarr [int];
  logic [15:0] ref_mem [int];
  logic        pv [LAT] = '{default: 1'b0};
  logic [15:0] pa [LAT] = '{default: 16'h0000};
  logic        iss_s = 1'b0;
  logic [15:0] iss_a = 16'h0000;

  function automatic logic [15:0] init_word(logic [15:0] a);
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] mem_word(logic [15:0] a);
    if (memarr.exists(int'(a[15:1]))) return memarr[int'(a[15:1])];
    return init_word(a);
  endfunction

  function automatic logic [15:0] ref_word(logic [15:0] a);
    if (ref_mem.exists(int'(a[15:1]))) return ref_mem[int'(a[15:1])];
    return init_word(a);
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    iss_s = mem_en && !mem_wr;
    iss_a = mem_addr;
    if (mem_en && mem_wr) memarr[int'(mem_addr[15:1])] = mem_wdata;
  end

  always @(posedge clk) begin
    #1;
    for (int k = LAT - 1; k > 0; k--) begin
      pv[k] = pv[k-1];
      pa[k] = pa[k-1];
    end
    pv[0] = iss_s;
    pa[0] = iss_a;
    mem_rvalid = pv[LAT-1];
    mem_rdata  = pv[LAT-1] ? mem_word(pa[LAT-1]) : 16'h0000;
  end

  // ---------------- monitor: log everything the DUT does ------------------
  always @(negedge clk) begin
    if (mem_en) iss_q.push_back('{cyc, mem_wr, mem_addr, mem_wdata});
    if (i_fill_we || d_fill_we)
      fil_q.push_back('{cyc, d_fill_we, int'(fill_word), fill_data, i_fill_done | d_fill_done});
    if (i_fill_done) begin saw_idone = 1'b1; idone_q.push_back(cyc); dn_order.push_back(0); end
    if (d_fill_done) begin saw_ddone = 1'b1; ddone_q.push_back(cyc); dn_order.push_back(1); end
    if (wr_done)     begin saw_wrdone = 1'b1; wrdone_q.push_back(cyc); end
  end

  // ---------------- reference model (transaction level) -------------------
  function automatic void model_fill(bit is_d, logic [15:0] addr);
    logic [15:0] base;
    logic [15:0] a;
    base = addr & BLK_MASK;
    for (int k = 0; k < WORDS; k++) begin
      a = base + 16'(2 * k);
      exp_iss.push_back('{0, 1'b0, a, 16'h0000});
      exp_fil.push_back('{0, is_d, k, ref_word(a), (k == WORDS - 1)});
    end
  endfunction

  function automatic void model_store(logic [15:0] addr, logic [15:0] data);
    exp_iss.push_back('{0, 1'b1, addr, data});
    ref_mem[int'(addr[15:1])] = data;
  endfunction

  // ---------------- stimulus plumbing -------------------------------------
  task automatic clear_logs();
    iss_q.delete(); fil_q.delete(); exp_iss.delete(); exp_fil.delete();
    idone_q.delete(); ddone_q.delete(); wrdone_q.delete(); dn_order.delete();
  endtask

  // Advance one cycle; requesters drop their request after its done pulse.
  task automatic step();
    @(posedge clk);
    #1;
    if (saw_idone && !hold_i) i_miss = 1'b0;
    if (saw_ddone && !hold_d) d_miss = 1'b0;
    if (saw_wrdone) d_wr = 1'b0;
    saw_idone = 1'b0; saw_ddone = 1'b0; saw_wrdone = 1'b0;
  endtask

  task automatic run_to_idle(input int maxc, output bit timeout);
    int n;
    n = 0;
    while ((i_miss || d_miss || d_wr || busy) && n < maxc) begin
      step();
      n++;
    end
    timeout = (n >= maxc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_miss = 1'b0; d_miss = 1'b0; d_wr = 1'b0; hold_i = 1'b0; hold_d = 1'b0;
    step(); step();
    rst = 1'b0;
    clear_logs();
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    logic [58:0] outs;
    @(negedge clk);
    outs = {mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
            i_fill_we, d_fill_we, i_fill_done, d_fill_done, wr_done, busy};
    total++;
    if (outs !== 59'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    do_reset();
    @(negedge clk);
    outs = {mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
            i_fill_we, d_fill_we, i_fill_done, d_fill_done, wr_done, busy};
    total++;
    if (outs !== 59'd0) begin bad++; $display("FAIL idle_after_reset got=%h exp=0", outs); end
  endtask

  task automatic test_i_fill();
    bit to;
    do_reset();
    model_fill(1'b0, 16'h1236);
    i_miss_addr = 16'h1236; i_miss = 1'b1;
    run_to_idle(60, to);
    total++;
    if (to) begin bad++; $display("FAIL i_fill_timeout got=timeout exp=idle"); end
    total++;
    if (iss_q.size() !== exp_iss.size()) begin
      bad++; $display("FAIL i_fill_issue_count got=%0d exp=%0d", iss_q.size(), exp_iss.size());
    end
    for (int k = 0; k < exp_iss.size() && k < iss_q.size(); k++) begin
      total++;
      if (iss_q[k].wr !== exp_iss[k].wr || iss_q[k].addr !== exp_iss[k].addr ||
          iss_q[k].cyc - iss_q[0].cyc !== k) begin
        bad++;
        $display("FAIL i_fill_issue[%0d] got wr=%0b addr=%h dcyc=%0d exp wr=%0b addr=%h dcyc=%0d",
                 k, iss_q[k].wr, iss_q[k].addr, iss_q[k].cyc - iss_q[0].cyc, exp_iss[k].wr, exp_iss[k].addr, k);
      end
    end
    total++;
    if (fil_q.size() !== exp_fil.size()) begin
      bad++; $display("FAIL i_fill_we_count got=%0d exp=%0d", fil_q.size(), exp_fil.size());
    end
    for (int k = 0; k < exp_fil.size() && k < fil_q.size(); k++) begin
      total++;
      if (fil_q[k].d !== exp_fil[k].d || fil_q[k].word !== exp_fil[k].word ||
          fil_q[k].data !== exp_fil[k].data || fil_q[k].done !== exp_fil[k].done) begin
        bad++;
        $display("FAIL i_fill_word[%0d] got d=%0b w=%0d data=%h done=%0b exp d=%0b w=%0d data=%h done=%0b",
                 k, fil_q[k].d, fil_q[k].word, fil_q[k].data, fil_q[k].done,
                 exp_fil[k].d, exp_fil[k].word, exp_fil[k].data, exp_fil[k].done);
      end
    end
    total++;
    if (idone_q.size() !== 1 || ddone_q.size() !== 0) begin
      bad++; $display("FAIL i_fill_done_count got i=%0d d=%0d exp i=1 d=0", idone_q.size(), ddone_q.size());
    end
  endtask

  task automatic test_priority();
    bit to;
    do_reset();
    model_fill(1'b1, 16'h0040);
    model_fill(1'b0, 16'h2000);
    d_miss_addr = 16'h0040; i_miss_addr = 16'h2000;
    d_miss = 1'b1; i_miss = 1'b1;
    run_to_idle(100, to);
    total++;
    if (to) begin bad++; $display("FAIL prio_timeout got=timeout exp=idle"); end
    total++;
    if (iss_q.size() !== exp_iss.size()) begin
      bad++; $display("FAIL prio_issue_count got=%0d exp=%0d", iss_q.size(), exp_iss.size());
    end
    for (int k = 0; k < exp_iss.size() && k < iss_q.size(); k++) begin
      total++;
      if (iss_q[k].wr !== exp_iss[k].wr || iss_q[k].addr !== exp_iss[k].addr) begin
        bad++;
        $display("FAIL prio_issue[%0d] got wr=%0b addr=%h exp wr=%0b addr=%h",
                 k, iss_q[k].wr, iss_q[k].addr, exp_iss[k].wr, exp_iss[k].addr);
      end
    end
    for (int k = 0; k < exp_fil.size() && k < fil_q.size(); k++) begin
      total++;
      if (fil_q[k].d !== exp_fil[k].d || fil_q[k].word !== exp_fil[k].word ||
          fil_q[k].data !== exp_fil[k].data || fil_q[k].done !== exp_fil[k].done) begin
        bad++;
        $display("FAIL prio_word[%0d] got d=%0b w=%0d data=%h exp d=%0b w=%0d data=%h",
                 k, fil_q[k].d, fil_q[k].word, fil_q[k].data, exp_fil[k].d, exp_fil[k].word, exp_fil[k].data);
      end
    end
    // D done, one IDLE cycle, then the first I issue.
    total++;
    if (ddone_q.size() !== 1 || iss_q.size() < 9 || iss_q[8].cyc !== ddone_q[0] + 2) begin
      bad++; $display("FAIL prio_gap got ddone=%0d issue_count=%0d exp first I issue two cycles after D done",
                      ddone_q.size(), iss_q.size());
    end
  endtask

  task automatic test_store();
    bit to;
    do_reset();
    model_store(16'h0102, 16'hBEEF);
    d_wr_addr = 16'h0102; d_wr_data = 16'hBEEF; d_wr = 1'b1;
    run_to_idle(20, to);
    total++;
    if (to || iss_q.size() !== 1) begin
      bad++; $display("FAIL store_count got=%0d exp=1", iss_q.size());
    end else begin
      total++;
      if (iss_q[0].wr !== 1'b1 || iss_q[0].addr !== 16'h0102 || iss_q[0].wdata !== 16'hBEEF) begin
        bad++; $display("FAIL store_fields got wr=%0b addr=%h data=%h exp wr=1 addr=0102 data=beef",
                        iss_q[0].wr, iss_q[0].addr, iss_q[0].wdata);
      end
      total++;
      if (wrdone_q.size() !== 1 || wrdone_q[0] !== iss_q[0].cyc || fil_q.size() !== 0) begin
        bad++; $display("FAIL store_wr_done got pulses=%0d fills=%0d exp pulses=1 fills=0",
                        wrdone_q.size(), fil_q.size());
      end
    end
  endtask

  task automatic test_store_during_fill();
    bit to;
    int n;
    do_reset();
    model_fill(1'b0, 16'h0A10);
    model_store(16'h0A14, 16'h1234);
    i_miss_addr = 16'h0A10; i_miss = 1'b1;
    n = 0;
    while (iss_q.size() < 1 && n < 10) begin step(); n++; end
    d_wr_addr = 16'h0A14; d_wr_data = 16'h1234; d_wr = 1'b1;
    run_to_idle(60, to);
    total++;
    if (to || iss_q.size() !== exp_iss.size()) begin
      bad++; $display("FAIL sdf_issue_count got=%0d exp=%0d", iss_q.size(), exp_iss.size());
    end
    for (int k = 0; k < exp_iss.size() && k < iss_q.size(); k++) begin
      total++;
      if (iss_q[k].wr !== exp_iss[k].wr || iss_q[k].addr !== exp_iss[k].addr ||
          (exp_iss[k].wr === 1'b1 && iss_q[k].wdata !== exp_iss[k].wdata)) begin
        bad++;
        $display("FAIL sdf_issue[%0d] got wr=%0b addr=%h exp wr=%0b addr=%h",
                 k, iss_q[k].wr, iss_q[k].addr, exp_iss[k].wr, exp_iss[k].addr);
      end
    end
    total++;
    if (idone_q.size() !== 1 || iss_q.size() < 9 || iss_q[8].cyc !== idone_q[0] + 2) begin
      bad++; $display("FAIL sdf_store_timing got idone=%0d issues=%0d exp store two cycles after I done",
                      idone_q.size(), iss_q.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    int n;
    logic [58:0] outs;
    do_reset();
    i_miss_addr = 16'h3458; i_miss = 1'b1;
    n = 0;
    while (fil_q.size() < 3 && n < 40) begin step(); n++; end
    #2;
    rst = 1'b1;
    #1;
    outs = {mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
            i_fill_we, d_fill_we, i_fill_done, d_fill_done, wr_done, busy};
    total++;
    if (fil_q.size() !== 3 || outs !== 59'd0) begin
      bad++; $display("FAIL mid_fill_reset got fills=%0d outs=%h exp fills=3 outs=0", fil_q.size(), outs);
    end
    i_miss = 1'b0;
    step(); step();
    rst = 1'b0;
    clear_logs();
    repeat (10) step();
    total++;
    if (fil_q.size() !== 0 || iss_q.size() !== 0) begin
      bad++; $display("FAIL stale_returns got fills=%0d issues=%0d exp 0 0", fil_q.size(), iss_q.size());
    end
  endtask

  task automatic test_random();
    bit to;
    int kind;
    logic [15:0] a, dat;
    for (int t = 0; t < 14; t++) begin
      clear_logs();
      kind = $urandom_range(0, 2);
      a    = 16'($urandom_range(0, 255)) & 16'hFFFE;
      dat  = 16'($urandom);
      if (kind == 0) begin
        model_fill(1'b0, a); i_miss_addr = a; i_miss = 1'b1;
      end else if (kind == 1) begin
        model_fill(1'b1, a); d_miss_addr = a; d_miss = 1'b1;
      end else begin
        model_store(a, dat); d_wr_addr = a; d_wr_data = dat; d_wr = 1'b1;
      end
      run_to_idle(60, to);
      total++;
      if (to || iss_q.size() !== exp_iss.size() || fil_q.size() !== exp_fil.size()) begin
        bad++; $display("FAIL rnd%0d_counts got iss=%0d fil=%0d exp iss=%0d fil=%0d",
                        t, iss_q.size(), fil_q.size(), exp_iss.size(), exp_fil.size());
      end
      for (int k = 0; k < exp_iss.size() && k < iss_q.size(); k++) begin
        total++;
        if (iss_q[k].wr !== exp_iss[k].wr || iss_q[k].addr !== exp_iss[k].addr ||
            (exp_iss[k].wr === 1'b1 && iss_q[k].wdata !== exp_iss[k].wdata)) begin
          bad++;
          $display("FAIL rnd%0d_issue[%0d] got wr=%0b addr=%h data=%h exp wr=%0b addr=%h data=%h",
                   t, k, iss_q[k].wr, iss_q[k].addr, iss_q[k].wdata, exp_iss[k].wr, exp_iss[k].addr, exp_iss[k].wdata);
        end
      end
      for (int k = 0; k < exp_fil.size() && k < fil_q.size(); k++) begin
        total++;
        if (fil_q[k].d !== exp_fil[k].d || fil_q[k].word !== exp_fil[k].word ||
            fil_q[k].data !== exp_fil[k].data || fil_q[k].done !== exp_fil[k].done) begin
          bad++;
          $display("FAIL rnd%0d_word[%0d] got d=%0b w=%0d data=%h exp d=%0b w=%0d data=%h",
                   t, k, fil_q[k].d, fil_q[k].word, fil_q[k].data, exp_fil[k].d, exp_fil[k].word, exp_fil[k].data);
        end
      end
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  task automatic test_arbitration();
    bit to, last_i;
    int n;
    int exp_ord[$];
    do_reset();
    last_i = 1'b1;
    for (int g = 0; g < 3; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_ord.push_back(last_i ? 1 : 0);
      last_i = ~last_i;
`else
      exp_ord.push_back(1);
`endif
    end
    hold_i = 1'b1; hold_d = 1'b1;
    d_miss_addr = 16'h0400; i_miss_addr = 16'h0800;
    d_miss = 1'b1; i_miss = 1'b1;
    n = 0;
    while (dn_order.size() < 3 && n < 150) begin step(); n++; end
    d_miss = 1'b0; i_miss = 1'b0; hold_i = 1'b0; hold_d = 1'b0;
    run_to_idle(40, to);
    total++;
    if (dn_order.size() !== 3) begin
      bad++; $display("FAIL arb_grant_count got=%0d exp=3", dn_order.size());
    end
    for (int g = 0; g < 3 && g < dn_order.size(); g++) begin
      total++;
      if (dn_order[g] !== exp_ord[g]) begin
        bad++; $display("FAIL arb_order[%0d] got=%0d exp=%0d (1=D 0=I)", g, dn_order[g], exp_ord[g]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_priority();
    test_store();
    test_store_during_fill();
    test_reset_mid_fill();
    test_random();
    test_arbitration();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
